brent_kung_adder32: RTL and testbench
=====================================

Name: brent_kung_adder32

Overview:
- 32-bit parallel-prefix adder using a Brent-Kung carry tree, with registered outputs.
- Computes a + b + cin and exposes the sum, the carry-out and the full internal carry vector.
- Used as a datapath arithmetic leaf wherever a fast, low-fanout 32-bit adder is needed. The carry vector supports debug and overflow logic.

Parameters:
- WIDTH, 32, operand width. The architecture is fixed at 32. Other values are unsupported; elaborate-time check is required.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- a  input  32  operand A, unsigned
- b  input  32  operand B, unsigned
- cin  input  1  carry-in
- sum  output  32  registered (a + b + cin) mod 2^32
- cout  output  1  registered carry out of bit 31
- c  output  32  registered carry vector; c[i] = carry INTO bit i, so c[0] = cin

Behaviour:
- Reset: rst high asynchronously forces sum=0, cout=0 and c=0, independent of clk. Outputs hold 0 while rst is high.
- Release: the first rising clk edge with rst low captures the current result.
- Latency: exactly 1 cycle. Inputs present before a rising edge appear on the outputs after that edge. Throughput is one add per cycle, with no handshake.
- Core is purely combinational:
  - Bit level: g[i] = a[i]&b[i], p[i] = a[i]^b[i].
  - Carry-in handling: cin is folded in as the generate of a virtual bit -1, i.e. G0' = g[0] | (p[0]&cin).
  - Up-sweep: log2(32)=5 levels combining spans 2,4,8,16,32. (G,P) o (G',P') = (G | P&G', P&P').
  - Down-sweep: 4 levels filling the remaining prefixes. Total prefix depth is 2*log2(N)-1 = 9 levels.
- Carry and sum formation:
  - c[0] = cin.
  - c[i] = prefix generate over bits [i-1:0] including cin, for i = 1..31.
  - cout = prefix generate over [31:0] including cin.
  - sum[i] = p[i] ^ c[i].
- Arithmetic is unsigned modulo 2^32; overflow is signalled only via cout. No signed overflow output.
- No X propagation from the carry tree. Every prefix node is driven on every path.
- Reset asserted mid-operation discards the pending result. After release, the outputs reflect the inputs sampled at the next edge.

Decomposition:
- Shared package brent_kung_pkg:
  - ADDER_WIDTH = 32
  - LOG2_WIDTH = 5
  - a packed struct pg_t {g, p} for generate/propagate pairs
- One sub-module: brent_kung_pg_cell.
  - Black cell computing (G,P) o (G',P').
  - A gray-cell variant is selected by parameter GRAY_ONLY, which omits P.
  - Instantiated via generate loops per tree level.
- Top module contains:
  - pg pre-processing
  - up-sweep and down-sweep generate loops
  - sum XOR
  - output register with async reset

Test Plan:
- rst=1 for 2 cycles with random inputs -> sum=0, cout=0, c=0. Then raise rst again mid-stream asynchronously (between edges) -> outputs go to 0 immediately.
- a=14576884, b=539574, cin=1 -> next cycle sum=15116459, cout=0, c[0]=1.
- a=27794585, b=67769764, cin=0 -> sum=95564349, cout=0. Then a=5734568, b=90867565, cin=1 -> sum=96602134, cout=0. Back-to-back inputs give back-to-back results.
- a=b=0x7FFFFFFF, cin=0 -> sum=0xFFFFFFFE, cout=0, c=0xFFFFFFFE. Then a=946878, b=4223357, cin=1 -> sum=5170236, cout=0.
- Wrap: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, c=0xFFFFFFFF. Also a=b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
- Random: 10k random a, b, cin checked each cycle against a 33-bit reference sum. Expected c = (a^b^sum_ref)[31:0], with c[0]=cin.

Source files
------------

// File: rtl/brent_kung_pkg.sv
// rtl/brent_kung_pkg.sv - shared constants and generate/propagate pair type for the Brent-Kung adder
package brent_kung_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int LOG2_WIDTH  = 5;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

endpackage

// File: rtl/brent_kung_pg_cell.sv
// rtl/brent_kung_pg_cell.sv - prefix operator cell (G,P) o (G',P'); gray variant drops P
module brent_kung_pg_cell
    import brent_kung_pkg::*;
#(
    parameter bit GRAY_ONLY = 1'b0
) (
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    // Gray cells sit where the group propagate is never consumed again
    assign o.p = GRAY_ONLY ? 1'b0 : (hi.p & lo.p);

endmodule

// File: rtl/brent_kung_adder32.sv
// rtl/brent_kung_adder32.sv - 32-bit Brent-Kung prefix adder with registered sum, carry-out and carry vector
module brent_kung_adder32
    import brent_kung_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] c
);

    localparam int UP_LEVELS = LOG2_WIDTH;
    localparam int TOP_LEVEL = 2 * LOG2_WIDTH - 1;

    if (WIDTH != ADDER_WIDTH) begin : g_width_check
        $error("brent_kung_adder32 supports WIDTH == 32 only");
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] c_next;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] unused_p;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar lv = 0; lv <= TOP_LEVEL; lv++) begin : g_lvl
        pg_t node [WIDTH-1:0];

        if (lv == 0) begin : g_pre
            // cin enters as the generate of a virtual bit -1 with no propagate
            assign node[0] = '{g: g[0] | (p[0] & cin), p: 1'b0};
            for (genvar i = 1; i < WIDTH; i++) begin : g_bit
                assign node[i] = '{g: g[i], p: p[i]};
            end
        end else if (lv <= UP_LEVELS) begin : g_up
            localparam int H = 2 ** (lv - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (((i + 1) % (2 * H)) == 0) begin : g_cell
                    brent_kung_pg_cell #(
                        .GRAY_ONLY(lv == UP_LEVELS)
                    ) u_cell (
                        .hi(g_lvl[lv-1].node[i]),
                        .lo(g_lvl[lv-1].node[i-H]),
                        .o (node[i])
                    );
                end else begin : g_pass
                    assign node[i] = g_lvl[lv-1].node[i];
                end
            end
        end else begin : g_down
            // Spans 8,4,2,1: each node borrows the finished prefix just below its group
            localparam int S = 2 ** (TOP_LEVEL - lv);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if ((((i + 1) % (2 * S)) == S) && (i >= 3 * S - 1)) begin : g_cell
                    brent_kung_pg_cell #(
                        .GRAY_ONLY(1'b1)
                    ) u_cell (
                        .hi(g_lvl[lv-1].node[i]),
                        .lo(g_lvl[lv-1].node[i-S]),
                        .o (node[i])
                    );
                end else begin : g_pass
                    assign node[i] = g_lvl[lv-1].node[i];
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign carry[i]    = g_lvl[TOP_LEVEL].node[i].g;
        assign unused_p[i] = g_lvl[TOP_LEVEL].node[i].p;
    end

    assign c_next   = {carry[WIDTH-2:0], cin};
    assign sum_next = p ^ c_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            c    <= '0;
        end else begin
            sum  <= sum_next;
            cout <= carry[WIDTH-1];
            c    <= c_next;
        end
    end

endmodule

// File: tb/tb_brent_kung_adder32.sv
// tb/tb_brent_kung_adder32.sv - randomized self-checking bench for brent_kung_adder32
module tb_brent_kung_adder32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;

    brent_kung_adder32 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum),
        .cout(cout),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one operand set, let one edge capture it, then compare against plain arithmetic
    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        logic [32:0] ref_full;
        logic [31:0] ref_c;
        a   = ta;
        b   = tb;
        cin = tc;
        ref_full = {1'b0, ta} + {1'b0, tb} + {32'd0, tc};
        ref_c    = ta ^ tb ^ ref_full[31:0];
        @(posedge clk);
        #1;
        check({tag, "_sum"}, sum, ref_full[31:0]);
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ref_full[32]});
        check({tag, "_c"}, c, ref_c);
    endtask

    initial begin
        rst = 1'b1;
        a   = $urandom;
        b   = $urandom;
        cin = 1'b1;

        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_sum", sum, 32'd0);
            check("rst_cout", {31'd0, cout}, 32'd0);
            check("rst_c", c, 32'd0);
            a = $urandom;
            b = $urandom;
        end
        rst = 1'b0;

        run("d1", 32'd14576884, 32'd539574, 1'b1);
        check("d1_const", sum, 32'd15116459);
        check("d1_c0", {31'd0, c[0]}, 32'd1);
        run("d2", 32'd27794585, 32'd67769764, 1'b0);
        check("d2_const", sum, 32'd95564349);
        run("d3", 32'd5734568, 32'd90867565, 1'b1);
        check("d3_const", sum, 32'd96602134);
        run("d4", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check("d4_const", sum, 32'hFFFF_FFFE);
        check("d4_cvec", c, 32'hFFFF_FFFE);
        run("d5", 32'd946878, 32'd4223357, 1'b1);
        check("d5_const", sum, 32'd5170236);
        run("wrap1", 32'hFFFF_FFFF, 32'd0, 1'b1);
        check("wrap1_cout", {31'd0, cout}, 32'd1);
        check("wrap1_cvec", c, 32'hFFFF_FFFF);
        run("wrap2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("wrap2_const", sum, 32'hFFFF_FFFF);

        // Mid-cycle assertion must clear outputs without waiting for an edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum", sum, 32'd0);
        check("arst_cout", {31'd0, cout}, 32'd0);
        check("arst_c", c, 32'd0);
        a   = 32'hDEAD_BEEF;
        b   = 32'h1234_5678;
        cin = 1'b1;
        @(posedge clk);
        #1;
        check("arst_hold_sum", sum, 32'd0);
        check("arst_hold_c", c, 32'd0);
        rst = 1'b0;
        run("post_rst", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        for (int k = 0; k < 10000; k++) begin
            run("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
